// File: rtl/lvds_frame_aligner_pkg.sv
// Shared types and helpers for the LVDS frame aligner: FSM state encoding,
// counter widths and saturating increments.
package lvds_frame_aligner_pkg;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  localparam int SLIP_CNT_W = 8;
  localparam int ERR_CNT_W  = 16;

  function automatic logic [SLIP_CNT_W-1:0] sat_inc8(input logic [SLIP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc16(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lvds_frame_aligner_lane_interleaver.sv
// Pure bit permutation from per-lane deserialised words to one sample word.
// Lane 0 carries the MSB; bit S-1 of each lane is the first bit received.
module lane_interleaver #(
  parameter int S       = 8,
  parameter int N_LANES = 2
) (
  input  logic [N_LANES*S-1:0] data_i,
  output logic [N_LANES*S-1:0] sample_o
);

  always_comb begin
    sample_o = '0;
    for (int k = 0; k < S; k++) begin
      for (int l = 0; l < N_LANES; l++) begin
        sample_o[N_LANES*S-1-(N_LANES*k+l)] = data_i[l*S+S-1-k];
      end
    end
  end

endmodule

// File: rtl/lvds_frame_aligner.sv
// Frame-lane word aligner and lane re-interleaver for a DDR ADC link.
// Optional FRAME_ALIGNER_TESTPAT_EN adds a test-pattern error counter.
//
// state     | meaning
// SEARCH    | restart search: clear match/slip counters and align_fail
// CHECK     | compare frame lane, count consecutive matches toward lock
// SLIP      | bitslip pulse is high this cycle; count the slip
// SETTLE    | let the ISERDES settle after a slip, no compares
// LOCKED    | aligned; count frame errors, drop lock on a run of them
module lvds_frame_aligner
  import lvds_frame_aligner_pkg::*;
#(
  parameter int             S             = 8,
  parameter int             N_LANES       = 2,
  parameter logic [S-1:0]   FRAME_PATTERN = 8'hF0,
  parameter int             SETTLE        = 16,
  parameter int             LOCK_COUNT    = 64,
  parameter int             ERR_THRESH    = 4
) (
  input  logic                    sample_clk,
  input  logic                    reset,
  input  logic [S-1:0]            frame_in,
  input  logic [N_LANES*S-1:0]    data_in,
  input  logic                    realign,
  output logic                    bitslip,
  output logic                    aligned,
  output logic                    align_fail,
  output logic [N_LANES*S-1:0]    sample_out,
  output logic                    sample_valid,
  output logic [SLIP_CNT_W-1:0]   slip_count,
  output logic [ERR_CNT_W-1:0]    err_count
`ifdef FRAME_ALIGNER_TESTPAT_EN
  ,
  input  logic [N_LANES*S-1:0]    test_pattern,
  output logic [ERR_CNT_W-1:0]    pat_err_count
`endif
);

  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam int CONSEC_W = $clog2(ERR_THRESH + 1);
  localparam int SMOD_W   = $clog2(S + 1);

  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [CONSEC_W-1:0] CONSEC_LAST = CONSEC_W'(ERR_THRESH - 1);
  localparam logic [SMOD_W-1:0]   SMOD_LAST   = SMOD_W'(S - 1);

  state_e                  state_q;
  logic [MATCH_W-1:0]      match_q;
  logic [SETTLE_W-1:0]     settle_q;
  logic [CONSEC_W-1:0]     consec_q;
  logic [SMOD_W-1:0]       slip_mod_q;
  logic                    bitslip_q;
  logic                    aligned_q;
  logic                    align_fail_q;
  logic [SLIP_CNT_W-1:0]   slip_count_q;
  logic [ERR_CNT_W-1:0]    err_count_q;
  logic [N_LANES*S-1:0]    sample_q;
  logic [N_LANES*S-1:0]    sample_d;
  logic                    sample_valid_q;
  logic                    frame_match;

  assign frame_match = (frame_in == FRAME_PATTERN);

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      match_q      <= '0;
      settle_q     <= '0;
      consec_q     <= '0;
      slip_mod_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_fail_q <= 1'b0;
      slip_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      bitslip_q <= 1'b0;
      // realign overrides whatever the current state would have done this edge
      if (realign) begin
        state_q      <= ST_SEARCH;
        aligned_q    <= 1'b0;
        align_fail_q <= 1'b0;
        slip_count_q <= '0;
        slip_mod_q   <= '0;
        match_q      <= '0;
        consec_q     <= '0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            match_q      <= '0;
            slip_count_q <= '0;
            slip_mod_q   <= '0;
            align_fail_q <= 1'b0;
            consec_q     <= '0;
            state_q      <= ST_CHECK;
          end
          ST_CHECK: begin
            if (frame_match) begin
              if (match_q == MATCH_LAST) begin
                state_q   <= ST_LOCKED;
                aligned_q <= 1'b1;
                consec_q  <= '0;
              end else begin
                match_q <= match_q + 1'b1;
              end
            end else begin
              match_q   <= '0;
              bitslip_q <= 1'b1;
              state_q   <= ST_SLIP;
            end
          end
          ST_SLIP: begin
            slip_count_q <= sat_inc8(slip_count_q);
            // a full word of slips has visited every bit phase without lock
            if (slip_mod_q == SMOD_LAST) begin
              slip_mod_q   <= '0;
              align_fail_q <= 1'b1;
            end else begin
              slip_mod_q <= slip_mod_q + 1'b1;
            end
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_q == '0) begin
              state_q <= ST_CHECK;
            end else begin
              settle_q <= settle_q - 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!frame_match) begin
              err_count_q <= sat_inc16(err_count_q);
              if (consec_q == CONSEC_LAST) begin
                state_q      <= ST_SEARCH;
                aligned_q    <= 1'b0;
                slip_count_q <= '0;
                slip_mod_q   <= '0;
                match_q      <= '0;
                consec_q     <= '0;
              end else begin
                consec_q <= consec_q + 1'b1;
              end
            end else begin
              consec_q <= '0;
            end
          end
          default: state_q <= ST_SEARCH;
        endcase
      end
    end
  end

  lane_interleaver #(
    .S       (S),
    .N_LANES (N_LANES)
  ) u_interleaver (
    .data_i   (data_in),
    .sample_o (sample_d)
  );

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= aligned_q;
    end
  end

`ifdef FRAME_ALIGNER_TESTPAT_EN
  logic [ERR_CNT_W-1:0] pat_err_q;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      pat_err_q <= '0;
    end else if (sample_valid_q && (sample_q != test_pattern)) begin
      pat_err_q <= sat_inc16(pat_err_q);
    end
  end

  assign pat_err_count = pat_err_q;
`endif

  assign bitslip      = bitslip_q;
  assign aligned      = aligned_q;
  assign align_fail   = align_fail_q;
  assign slip_count   = slip_count_q;
  assign err_count    = err_count_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;

endmodule
